// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer owning PC/IF-ID enables, ID/EX bubble, branch flush and MEM-wait freeze.
// Control outputs are combinational from state and inputs; err_o and the perf counters are registered.
// Optional perf counters are built only when PIPE_CTRL_PERF_CNT_EN is defined.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_uses_rs2_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        branch_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        idex_bubble_o,
  output logic        flush_o,
  output logic        freeze_o,
  output logic        mem_req_o,
  output logic        err_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_events_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_HALT} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q;
  logic       err_q;
  logic       load_use;
  logic       mem_block;

  assign load_use  = ex_memread_i && (ex_rd_i != 5'd0) &&
                     ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));
  assign mem_block = mem_req_i && !mem_ack_i;

  // State register, wait counter (cleared whenever not waiting) and sticky error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= (state_q == S_WAIT) ? wait_cnt_q + 8'd1 : 8'd0;
      if (state_q == S_WAIT && state_d == S_HALT)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (mem_block) state_d = S_WAIT;
      S_WAIT: begin
        if (mem_ack_i)
          state_d = S_RUN;
        else if (wait_cnt_q == TIMEOUT_LAST)
          state_d = S_HALT;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    idex_bubble_o = 1'b0;
    flush_o       = 1'b0;
    freeze_o      = 1'b0;
    mem_req_o     = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (mem_block) begin
          freeze_o  = 1'b1;
          mem_req_o = 1'b1;
        end else begin
          mem_req_o = mem_req_i;
          if (branch_taken_i) begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            flush_o      = 1'b1;
          end else if (load_use) begin
            idex_bubble_o = 1'b1;
          end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
          end
        end
      end
      S_WAIT: begin
        mem_req_o = 1'b1;
        // The ack cycle releases the freeze and acts as a normal RUN cycle
        if (!mem_ack_i) begin
          freeze_o = 1'b1;
        end else if (branch_taken_i) begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          flush_o      = 1'b1;
        end else if (load_use) begin
          idex_bubble_o = 1'b1;
        end else begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
        end
      end
      default: freeze_o = 1'b1;
    endcase
  end

  assign err_o = err_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;
  logic        active;

  assign active = (state_q == S_RUN) || (state_q == S_WAIT);

  // Saturating counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (active && !pc_write_o && stall_q != 32'hFFFF_FFFF)
        stall_q <= stall_q + 32'd1;
      if (flush_o && flush_q != 32'hFFFF_FFFF)
        flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
  assign flush_events_o = flush_q;
`else
  assign stall_cycles_o = 32'd0;
  assign flush_events_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (MEM_TIMEOUT=4): expected vectors queued at drive, compared at sample.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ctrl = {pc_write, ifid_write, idex_bubble, flush, freeze, mem_req}
  localparam logic [5:0] C_IDLE = 6'b000010;
  localparam logic [5:0] C_RUN  = 6'b110000;
  localparam logic [5:0] C_BUB  = 6'b001000;
  localparam logic [5:0] C_BR   = 6'b110100;
  localparam logic [5:0] C_WAIT = 6'b000011;
  localparam logic [5:0] C_ACK  = 6'b110001;
  localparam logic [5:0] C_ACKB = 6'b001001;

  typedef struct packed {
    logic [5:0]  ctrl;
    logic        err;
    logic [31:0] stall;
    logic [31:0] flush;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, uses_rs2, ex_memread, br, mreq, mack;
  logic [4:0]  rs1, rs2, ex_rd;
  logic        pc_write, ifid_write, bubble, flush, freeze, mem_req_o, err;
  logic [31:0] stall_cnt, flush_cnt;

  vec_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] acc_stall = 32'd0;
  logic [31:0] acc_flush = 32'd0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_uses_rs2_i(uses_rs2),
    .ex_memread_i(ex_memread), .ex_rd_i(ex_rd),
    .branch_taken_i(br), .mem_req_i(mreq), .mem_ack_i(mack),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .idex_bubble_o(bubble),
    .flush_o(flush), .freeze_o(freeze), .mem_req_o(mem_req_o), .err_o(err),
    .stall_cycles_o(stall_cnt), .flush_events_o(flush_cnt)
  );

  task automatic clr_in();
    rst = 1'b0; start = 1'b0; rs1 = 5'd0; rs2 = 5'd0; uses_rs2 = 1'b0;
    ex_memread = 1'b0; ex_rd = 5'd0; br = 1'b0; mreq = 1'b0; mack = 1'b0;
  endtask

  // Inputs are set by the caller just after a posedge; st marks a RUN/MEM_WAIT cycle.
  task automatic step(input string tag, input logic [5:0] ctrl, input logic e_err, input bit st);
    vec_t e, o;
    e = '{ctrl, e_err, acc_stall, acc_flush};
    exp_q.push_back(e);
    #2;
    o = '{{pc_write, ifid_write, bubble, flush, freeze, mem_req_o}, err, stall_cnt, flush_cnt};
    e = exp_q.pop_front();
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
    if (PERF && st && !ctrl[5]) acc_stall = acc_stall + 32'd1;
    if (PERF && ctrl[2])        acc_flush = acc_flush + 32'd1;
    @(posedge clk); #1;
  endtask

  initial begin
    clr_in();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset state, start at cycle 3
    step("idle_c0", C_IDLE, 1'b0, 1'b0);
    step("idle_c1", C_IDLE, 1'b0, 1'b0);
    step("idle_c2", C_IDLE, 1'b0, 1'b0);
    start = 1'b1;
    step("idle_c3_start", C_IDLE, 1'b0, 1'b0);
    start = 1'b0;
    step("run_c4", C_RUN, 1'b0, 1'b1);

    // Load-use on rs2
    ex_memread = 1'b1; ex_rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5; uses_rs2 = 1'b1;
    step("lu_rs2", C_BUB, 1'b0, 1'b1);
    clr_in();
    step("after_lu", C_RUN, 1'b0, 1'b1);
    ex_memread = 1'b1; ex_rd = 5'd5; rs2 = 5'd5; uses_rs2 = 1'b0;
    step("rs2_unused", C_RUN, 1'b0, 1'b1);
    ex_memread = 1'b1; ex_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; uses_rs2 = 1'b1;
    step("rd_zero", C_RUN, 1'b0, 1'b1);
    ex_memread = 1'b1; ex_rd = 5'd7; rs1 = 5'd7;
    step("lu_rs1", C_BUB, 1'b0, 1'b1);
    clr_in();

    // Taken branch
    br = 1'b1;
    step("branch", C_BR, 1'b0, 1'b1);
    br = 1'b0;
    step("after_branch", C_RUN, 1'b0, 1'b1);

    // Memory access acked after 3 cycles
    mreq = 1'b1;
    step("mem_req", C_WAIT, 1'b0, 1'b1);
    step("mem_wait0", C_WAIT, 1'b0, 1'b1);
    step("mem_wait1", C_WAIT, 1'b0, 1'b1);
    mack = 1'b1;
    step("mem_ack", C_ACK, 1'b0, 1'b1);
    clr_in();
    step("after_ack", C_RUN, 1'b0, 1'b1);

    // Ack in the request cycle costs nothing
    mreq = 1'b1; mack = 1'b1;
    step("mem_fast", C_ACK, 1'b0, 1'b1);
    clr_in();

    // Memory beats a simultaneous branch; ack cycle applies load-use
    mreq = 1'b1; br = 1'b1;
    step("mem_vs_br", C_WAIT, 1'b0, 1'b1);
    br = 1'b0; mack = 1'b1; ex_memread = 1'b1; ex_rd = 5'd9; rs1 = 5'd9;
    step("ack_lu", C_ACKB, 1'b0, 1'b1);
    clr_in();
    step("after_ack_lu", C_RUN, 1'b0, 1'b1);

    // Reset in the second MEM_WAIT cycle
    mreq = 1'b1;
    step("rw_req", C_WAIT, 1'b0, 1'b1);
    step("rw_wait0", C_WAIT, 1'b0, 1'b1);
    rst = 1'b1;
    step("rw_wait1_rst", C_WAIT, 1'b0, 1'b1);
    acc_stall = 32'd0; acc_flush = 32'd0;
    rst = 1'b0;
    step("rw_idle", C_IDLE, 1'b0, 1'b0);

    // Timeout: 4 wait cycles without ack, then HALT
    clr_in();
    start = 1'b1;
    step("to_start", C_IDLE, 1'b0, 1'b0);
    start = 1'b0; mreq = 1'b1;
    step("to_req", C_WAIT, 1'b0, 1'b1);
    step("to_wait0", C_WAIT, 1'b0, 1'b1);
    step("to_wait1", C_WAIT, 1'b0, 1'b1);
    step("to_wait2", C_WAIT, 1'b0, 1'b1);
    step("to_wait3", C_WAIT, 1'b0, 1'b1);
    step("halt", C_IDLE, 1'b1, 1'b0);
    start = 1'b1;
    step("halt_start", C_IDLE, 1'b1, 1'b0);
    clr_in();
    rst = 1'b1;
    step("halt_rst", C_IDLE, 1'b1, 1'b0);
    acc_stall = 32'd0; acc_flush = 32'd0;
    rst = 1'b0;
    step("idle_after_halt", C_IDLE, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencer for the 5-stage RISC-V core: owns PCWrite, IF/ID write-enable, ID/EX bubble insertion, flushes on taken branches, and freezes the whole pipe while a MEM-stage load/store waits on a multi-cycle data memory. It replaces the hard-wired `PCWrite = 1` in the top level and sits beside the Control unit, observing ID/EX/MEM-stage fields and driving enables into PC and the pipeline registers.

## Interface
- MEM_TIMEOUT, 64, max cycles MEM_WAIT may last before a fatal error (2..255)
- clk_i  in  1  core clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  leave IDLE and begin fetching
- id_rs1_i  in  5  RS1addr of instruction in ID
- id_rs2_i  in  5  RS2addr of instruction in ID
- id_uses_rs2_i  in  1  ID instruction reads rs2 (R, STORE, BRANCH)
- ex_memread_i  in  1  MemRead_EX
- ex_rd_i  in  5  rd of instruction in EX
- branch_taken_i  in  1  PCSrc from MEM stage
- mem_req_i  in  1  MemRead_MEM | MemWrite_MEM
- mem_ack_i  in  1  data memory completes access this cycle
- pc_write_o  out  1  PC load enable
- ifid_write_o  out  1  IF/ID load enable
- idex_bubble_o  out  1  zero ID/EX control fields on load
- flush_o  out  1  clear IF/ID, ID/EX, EX/MEM valid/control
- freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB
- mem_req_o  out  1  request to data memory
- err_o  out  1  registered sticky memory-timeout error
- stall_cycles_o  out  32  perf counter (see Configuration)
- flush_events_o  out  32  perf counter (see Configuration)

## Operation
- States: IDLE, RUN, MEM_WAIT, HALT. Reset -> IDLE.
- IDLE: pc_write 0, ifid_write 0, freeze 1, flush/bubble/mem_req 0. start_i=1 -> RUN. start_i is ignored in other states.
- RUN, priority high to low (one action per cycle):
  - mem_req_i & !mem_ack_i: pc_write 0, ifid_write 0, freeze 1, mem_req_o 1; -> MEM_WAIT, wait counter cleared to 0.
  - branch_taken_i: pc_write 1 (target selected by PCSrc), flush_o 1, ifid_write 1; stay RUN.
  - load-use: ex_memread_i & ex_rd_i!=0 & (ex_rd_i==id_rs1_i | (id_uses_rs2_i & ex_rd_i==id_rs2_i)): pc_write 0, ifid_write 0, idex_bubble 1.
  - otherwise: pc_write 1, ifid_write 1, all else 0; mem_req_o = mem_req_i.
- MEM_WAIT: freeze 1, pc_write 0, ifid_write 0, mem_req_o 1; counter +1 per cycle. mem_ack_i=1: that cycle behaves as RUN with the access complete (freeze 0, load-use check applied), -> RUN. Counter reaching MEM_TIMEOUT-1 with no ack -> HALT.
- HALT: as IDLE outputs, err_o 1; exits only on rst_i.
- branch_taken_i and mem_req_i are mutually exclusive (same MEM instruction); if both, memory wins.
- Wait counter 8 bits, no wrap possible given MEM_TIMEOUT ≤ 255.

## Timing
- All control outputs combinational from state + inputs; err_o and counters registered.
- Reset values: state IDLE, wait counter 0, err_o 0, both perf counters 0; hence pc_write 0, ifid_write 0, freeze 1, others 0.
- Load-use costs exactly 1 bubble; taken branch costs 3 flushed slots; memory access with ack in the request cycle costs 0 cycles, ack after N wait cycles costs N.
- rst_i in any state (including mid-MEM_WAIT) -> IDLE next edge; outstanding request dropped (mem_req_o 0 from next cycle).
- err_o rises the edge MEM_WAIT -> HALT.

## Configuration
- PIPE_CTRL_PERF_CNT_EN defined: stall_cycles_o increments each cycle pc_write_o=0 in RUN or MEM_WAIT; flush_events_o increments each cycle flush_o=1; both saturate at 0xFFFF_FFFF, clear on rst_i.
- Undefined: both counter ports tied to 0, no counter flops.

## Test plan
- Reset, start_i=1 at cycle 3 -> pc_write_o 0 cycles 0-3, 1 from cycle 4; freeze_o 1 until then.
- ld x5 in EX, add in ID reading x5 (rs2, id_uses_rs2=1) -> 1 cycle pc_write 0, idex_bubble 1, then normal; ex_rd=0 case -> no stall.
- branch_taken_i for 1 cycle -> flush_o 1, pc_write 1 same cycle; with PERF_CNT_EN flush_events_o=1.
- mem_req_i with ack after 3 cycles -> freeze_o 1 for exactly 3 cycles, released on ack cycle; stall_cycles_o=3.
- MEM_TIMEOUT=4, ack never -> HALT after 4 wait cycles, err_o 1, then rst_i -> IDLE, err_o 0.
- rst_i asserted in cycle 2 of MEM_WAIT -> IDLE next edge, mem_req_o 0, counters 0.
